// File: rtl/reset_seq_pkg.sv
// Shared constants and helpers for the staged reset sequencer.
// Provides the FSM state codes, the counter-width function and the parameter check.
package reset_seq_pkg;

    // FSM state codes; also driven onto the debug state port
    localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] ST_POR_WAIT  = 3'd1;
    localparam logic [2:0] ST_RELEASE   = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;

    // One counter serves every delay, so it is sized for the longest one
    function automatic int cnt_width(input int por, input int gap, input int hold);
        int m;
        m = por;
        if (gap > m) m = gap;
        if (hold > m) m = hold;
        return $clog2(m) + 1;
    endfunction

    function automatic bit params_ok(input int num_ch, input int por, input int gap,
                                     input int filt, input int hold);
        return (num_ch >= 1) && (por >= 1) && (gap >= 1) &&
               (filt >= 1) && (hold >= 1);
    endfunction

endpackage

// File: rtl/lock_filter.sv
// Debounces a synchronised PLL lock: lock_ok rises after LOCK_FILT consecutive high samples.
// Ports: clk, rst (sync, active-high), pll_locked in; lock_ok registered out.
module lock_filter #(
    parameter int LOCK_FILT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    output logic lock_ok
);

    localparam int LW = $clog2(LOCK_FILT + 1);
    localparam logic [LW-1:0] FILT = LW'(LOCK_FILT);

    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_ok_q, lock_ok_d;

    // Count saturates at FILT; any low sample restarts the run
    always_comb begin
        lock_cnt_d = '0;
        if (pll_locked) begin
            if (lock_cnt_q == FILT) lock_cnt_d = FILT;
            else                    lock_cnt_d = lock_cnt_q + 1'b1;
        end
        lock_ok_d = (lock_cnt_d == FILT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt_q <= '0;
            lock_ok_q  <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_ok_q  <= lock_ok_d;
        end
    end

    assign lock_ok = lock_ok_q;

endmodule

// File: rtl/reset_sequencer.sv
// Waits for a debounced PLL lock and a power-on delay, then releases NUM_CH
// active-low domain resets in order 0..NUM_CH-1, STAGE_GAP cycles apart.
// A soft request re-sequences after MIN_ASSERT cycles of hold, skipping the POR delay.
// Ports: clk, rst (sync, active-high), pll_locked, soft_rst_req in;
//        ch_rst_n[NUM_CH], all_done, state[3] registered out.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int POR_CYCLES = 1000,
    parameter int STAGE_GAP  = 16,
    parameter int LOCK_FILT  = 8,
    parameter int MIN_ASSERT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              soft_rst_req,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              all_done,
    output logic [2:0]        state
);

    if (!params_ok(NUM_CH, POR_CYCLES, STAGE_GAP, LOCK_FILT, MIN_ASSERT)) begin : g_bad_params
        $error("reset_sequencer: all parameters must be >= 1");
    end

    localparam int CW = cnt_width(POR_CYCLES, STAGE_GAP, MIN_ASSERT);
    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Terminal values are one less than the delay: the edge that sees
    // the terminal count is itself the last cycle of the delay
    localparam logic [CW-1:0] POR_LAST  = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_ASSERT - 1);
    localparam logic [SW-1:0] LAST_CH   = SW'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] CH0   = NUM_CH'(1);

    logic              lock_ok;
    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [NUM_CH-1:0] ch_q, ch_d;
    logic              done_q, done_d;
    logic [SW-1:0]     next_stage;
    logic              start_rel;
    logic              go_hold;

    lock_filter #(
        .LOCK_FILT (LOCK_FILT)
    ) u_lock_filter (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .lock_ok    (lock_ok)
    );

    assign next_stage = stage_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        ch_d      = ch_q;
        done_d    = done_q;
        start_rel = 1'b0;
        go_hold   = 1'b0;

        case (state_q)
            ST_WAIT_LOCK: begin
                ch_d   = '0;
                done_d = 1'b0;
                if (lock_ok) begin
                    state_d = ST_POR_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_POR_WAIT: begin
                if (cnt_q == POR_LAST) start_rel = 1'b1;
                else                   cnt_d = cnt_q + 1'b1;
            end
            ST_RELEASE: begin
                if (soft_rst_req) begin
                    go_hold = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    stage_d = next_stage;
                    ch_d    = ch_q | (CH0 << next_stage);
                    if (next_stage == LAST_CH) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (soft_rst_req) go_hold = 1'b1;
            end
            ST_HOLD: begin
                if (soft_rst_req)           cnt_d = '0;
                else if (cnt_q == HOLD_LAST) start_rel = 1'b1;
                else                        cnt_d = cnt_q + 1'b1;
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
                stage_d = '0;
                ch_d    = '0;
                done_d  = 1'b0;
            end
        endcase

        if (go_hold) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            stage_d = '0;
            ch_d    = '0;
            done_d  = 1'b0;
        end

        // With a single channel, releasing channel 0 finishes the sequence
        if (start_rel) begin
            cnt_d   = '0;
            stage_d = '0;
            ch_d    = CH0;
            if (NUM_CH == 1) begin
                state_d = ST_RUN;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RELEASE;
                done_d  = 1'b0;
            end
        end

        // Raw lock loss aborts immediately, bypassing the filter latency
        if (!pll_locked) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            stage_d = '0;
            ch_d    = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            stage_q <= '0;
            ch_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            ch_q    <= ch_d;
            done_q  <= done_d;
        end
    end

    assign ch_rst_n = ch_q;
    assign all_done = done_q;
    assign state    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: directed test-plan scenarios then random traffic.
// The reference model tracks release times as absolute edge numbers.
module tb_reset_sequencer;

    localparam int NUM_CH     = 3;
    localparam int POR_CYCLES = 20;
    localparam int STAGE_GAP  = 4;
    localparam int LOCK_FILT  = 3;
    localparam int MIN_ASSERT = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pll_locked = 1'b0;
    logic              soft_rst_req = 1'b0;
    logic [NUM_CH-1:0] ch_rst_n;
    logic              all_done;
    logic [2:0]        state;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] sbq[$];

    // Reference model state: absolute edge numbers of key events
    int  e = 0;
    int  run = 0;
    bit  seq = 0;
    bit  hold = 0;
    int  q = 0;
    int  t0 = 0;

    reset_sequencer #(
        .NUM_CH     (NUM_CH),
        .POR_CYCLES (POR_CYCLES),
        .STAGE_GAP  (STAGE_GAP),
        .LOCK_FILT  (LOCK_FILT),
        .MIN_ASSERT (MIN_ASSERT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .ch_rst_n     (ch_rst_n),
        .all_done     (all_done),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit r, input bit p, input bit s);
        e++;
        if (r) begin
            seq = 0;
            run = 0;
        end else if (!p) begin
            seq = 0;
            run = 0;
        end else begin
            // Soft request counts only in RELEASE/RUN (after t0) or HOLD
            if (seq && s && ((e > t0) || (hold && e <= t0))) begin
                t0   = e + MIN_ASSERT;
                hold = 1;
            end
            if (run < LOCK_FILT) begin
                run++;
                if (run == LOCK_FILT && !seq) begin
                    seq  = 1;
                    q    = e;
                    t0   = e + POR_CYCLES + 1;
                    hold = 0;
                end
            end
        end
    endtask

    function automatic logic [6:0] model_out();
        int n;
        logic [2:0] ch;
        if (!seq || e == q) return {3'b000, 1'b0, 3'd0};
        if (e < t0) return {3'b000, 1'b0, hold ? 3'd4 : 3'd1};
        n = (e - t0) / STAGE_GAP + 1;
        if (n > NUM_CH) n = NUM_CH;
        ch = 3'((1 << n) - 1);
        return {ch, (n == NUM_CH), (n == NUM_CH) ? 3'd3 : 3'd2};
    endfunction

    task automatic step(input bit r, input bit p, input bit s);
        @(negedge clk);
        rst = r;
        pll_locked = p;
        soft_rst_req = s;
        @(posedge clk);
        model_step(r, p, s);
        sbq.push_back(model_out());
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
        end
    endtask

    // Monitor: outputs are registered, so compare on the falling edge
    always @(negedge clk) begin
        logic [6:0] exp;
        if (sbq.size() > 0) begin
            exp = sbq.pop_front();
            n_checks++;
            if ({ch_rst_n, all_done, state} !== exp) begin
                n_errors++;
                $display("FAIL scoreboard edge %0d: ch=%b done=%b st=%0d expected ch=%b done=%b st=%0d",
                         e, ch_rst_n, all_done, state, exp[6:4], exp[3], exp[2:0]);
            end
        end
    end

    initial begin
        bit p;
        bit s;
        bit r;
        int quiet;

        step(1, 0, 0);
        #1 chk("reset_state", {ch_rst_n, all_done, state}, 0);
        step(1, 0, 0);

        // Cold start: pll high from edge 1
        for (int k = 1; k <= 40; k++) begin
            step(0, 1, 0);
            #1;
            if (k == 23) chk("cold_ch_e23", ch_rst_n, 0);
            if (k == 24) chk("cold_ch_e24", ch_rst_n, 1);
            if (k == 27) chk("cold_ch_e27", ch_rst_n, 1);
            if (k == 28) chk("cold_ch_e28", ch_rst_n, 3);
            if (k == 31) chk("cold_done_e31", all_done, 0);
            if (k == 32) chk("cold_ch_e32", ch_rst_n, 7);
            if (k == 32) chk("cold_done_e32", all_done, 1);
            if (k == 32) chk("cold_state_e32", state, 3);
        end

        // Soft request in RUN
        step(0, 1, 1);
        #1 chk("soft_clear", {ch_rst_n, all_done, state}, {3'b000, 1'b0, 3'd4});
        for (int k = 1; k <= 13; k++) begin
            step(0, 1, 0);
            #1;
            if (k == 4) chk("soft_ch_n4", ch_rst_n, 0);
            if (k == 5) chk("soft_ch_n5", ch_rst_n, 1);
            if (k == 13) chk("soft_done_n13", all_done, 1);
        end

        // Soft and lock loss together: loss wins
        step(0, 0, 1);
        #1 chk("simul_state", state, 0);

        // Relock with soft request during POR_WAIT (ignored)
        for (int k = 1; k <= 24; k++) begin
            step(0, 1, (k == 10));
            #1;
            if (k == 23) chk("porsoft_ch_e23", ch_rst_n, 0);
            if (k == 24) chk("porsoft_ch_e24", ch_rst_n, 1);
        end

        // Lock loss mid-RELEASE
        step(0, 0, 0);
        #1 chk("loss_state", state, 0);

        // Random traffic, alternating quiet and noisy lock phases
        for (int i = 0; i < 6000; i++) begin
            quiet = ((i / 400) % 2 == 0);
            r = ($urandom_range(0, 399) == 0);
            p = quiet ? 1'b1 : ($urandom_range(0, 39) != 0);
            if (!quiet && $urandom_range(0, 2) == 0) p = 1'b1;
            s = ($urandom_range(0, 29) == 0);
            step(r, p, s);
        end

        step(0, 1, 0);
        @(negedge clk);
        #1 chk("scoreboard_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
